// File: rtl/fft_iter_ctrl.sv
// Sequencing controller for an iterative radix-2 DIT FFT: issues butterfly read pairs,
// strobes the twiddle generator, and replays each read pair as a write-back BF_LAT cycles later.
module fft_iter_ctrl #(
  parameter int AWL    = 5,
  parameter int BF_LAT = 3,
  parameter int LWL    = 3
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           start_i,
  input  logic           hold_i,
  output logic           rd_en_o,
  output logic [AWL-1:0] rd_addr_a_o,
  output logic [AWL-1:0] rd_addr_b_o,
  output logic           w_en_o,
  output logic           lay_en_o,
  output logic           wr_en_o,
  output logic [AWL-1:0] wr_addr_a_o,
  output logic [AWL-1:0] wr_addr_b_o,
  output logic [LWL-1:0] layer_o,
  output logic           busy_o,
  output logic           done_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;

  localparam int KW  = AWL - 1;
  localparam int DCW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

  localparam logic [KW-1:0]  K_LAST = '1;
  localparam logic [LWL-1:0] S_LAST = LWL'(AWL - 1);
  localparam logic [DCW-1:0] D_LAST = DCW'(BF_LAT - 1);

  typedef struct packed {
    logic           en;
    logic [AWL-1:0] a;
    logic [AWL-1:0] b;
  } wr_slot_t;

  logic [1:0]     state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [LWL-1:0] s_q, s_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic [AWL-1:0] addr_a_q, addr_b_q;
  wr_slot_t       pipe_q [BF_LAT];

  logic           issue;
  logic           last_issue;
  logic [AWL-1:0] k_ext;
  logic [AWL-1:0] low_mask;
  logic [AWL-1:0] addr_a_now;
  logic [AWL-1:0] addr_b_now;

  assign issue      = (state_q == ST_RUN) && !hold_i;
  assign last_issue = issue && (k_q == K_LAST);

  // Upper leg: k with a zero spliced in at bit s; lower leg sets that bit.
  always_comb begin
    k_ext      = AWL'(k_q);
    low_mask   = (AWL'(1) << s_q) - AWL'(1);
    addr_a_now = ((k_ext & ~low_mask) << 1) | (k_ext & low_mask);
    addr_b_now = addr_a_now | (AWL'(1) << s_q);
  end

  // NOTE: every signal assigned here gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    s_d     = s_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RUN;
          k_d     = '0;
          s_d     = '0;
        end
      end
      ST_RUN: begin
        if (issue) begin
          k_d = k_q + 1'b1;
          if (last_issue) begin
            state_d = ST_DRAIN;
            dcnt_d  = '0;
          end
        end
      end
      ST_DRAIN: begin
        if (dcnt_q == D_LAST) begin
          if (s_q == S_LAST) begin
            state_d = ST_FIN;
          end else begin
            s_d     = s_q + 1'b1;
            state_d = ST_RUN;
          end
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        s_d     = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      s_q      <= '0;
      dcnt_q   <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      s_q     <= s_d;
      dcnt_q  <= dcnt_d;
      if (issue) begin
        addr_a_q <= addr_a_now;
        addr_b_q <= addr_b_now;
      end
    end
  end

  // NOTE: unlike a data RAM, this delay line is reset so in-flight write strobes die with the transform.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < BF_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= '{en: issue, a: rd_addr_a_o, b: rd_addr_b_o};
      for (int i = 1; i < BF_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Addresses hold the last issued pair whenever nothing is issued.
  assign rd_en_o     = issue;
  assign w_en_o      = issue;
  assign lay_en_o    = last_issue;
  assign rd_addr_a_o = issue ? addr_a_now : addr_a_q;
  assign rd_addr_b_o = issue ? addr_b_now : addr_b_q;

  assign wr_en_o     = pipe_q[BF_LAT-1].en;
  assign wr_addr_a_o = pipe_q[BF_LAT-1].a;
  assign wr_addr_b_o = pipe_q[BF_LAT-1].b;

  assign layer_o = s_q;
  assign busy_o  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done_o  = (state_q == ST_FIN);

endmodule

// File: tb/tb_fft_iter_ctrl.sv
// Scoreboard bench for fft_iter_ctrl: the stimulus plans each transform's issue schedule
// arithmetically and queues expectations; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_fft_iter_ctrl;

  localparam int AWL    = 4;
  localparam int BF_LAT = 3;
  localparam int LWL    = 3;
  localparam int N      = 1 << AWL;
  localparam int HALF   = N / 2;
  localparam int NB     = HALF * AWL;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           hold = 1'b0;
  logic           rd_en_o, w_en_o, lay_en_o, wr_en_o, busy_o, done_o;
  logic [AWL-1:0] rd_addr_a_o, rd_addr_b_o, wr_addr_a_o, wr_addr_b_o;
  logic [LWL-1:0] layer_o;

  fft_iter_ctrl #(.AWL(AWL), .BF_LAT(BF_LAT), .LWL(LWL)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .hold_i      (hold),
    .rd_en_o     (rd_en_o),
    .rd_addr_a_o (rd_addr_a_o),
    .rd_addr_b_o (rd_addr_b_o),
    .w_en_o      (w_en_o),
    .lay_en_o    (lay_en_o),
    .wr_en_o     (wr_en_o),
    .wr_addr_a_o (wr_addr_a_o),
    .wr_addr_b_o (wr_addr_b_o),
    .layer_o     (layer_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int a; int b; int s; bit lay; } rd_ev_t;
  typedef struct { int cyc; int a; int b; } wr_ev_t;
  typedef struct { int t0; int done; } xf_t;

  rd_ev_t rd_q[$];
  wr_ev_t wr_q[$];
  xf_t    xf_q[$];

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int last_a = 0;
  int last_b = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Butterfly k of layer s: upper leg is k with a zero inserted at bit s.
  function automatic int leg_a(input int k, input int s);
    return (k / (1 << s)) * (1 << (s + 1)) + (k % (1 << s));
  endfunction

  always @(negedge clk) begin : monitor
    rd_ev_t re;
    wr_ev_t we;
    bit     exp_rd, exp_wr, exp_busy, exp_done;

    exp_rd = (rd_q.size() > 0) && (rd_q[0].cyc == cyc);
    check("rd_en", rd_en_o, exp_rd);
    if (exp_rd) begin
      re = rd_q.pop_front();
      check("rd_addr_a", rd_addr_a_o, re.a);
      check("rd_addr_b", rd_addr_b_o, re.b);
      check("layer", layer_o, re.s);
      check("w_en", w_en_o, 1);
      check("lay_en", lay_en_o, re.lay);
      last_a = re.a;
      last_b = re.b;
    end else begin
      check("w_en_idle", w_en_o, 0);
      check("lay_en_idle", lay_en_o, 0);
    end

    exp_wr = (wr_q.size() > 0) && (wr_q[0].cyc == cyc);
    check("wr_en", wr_en_o, exp_wr);
    if (exp_wr) begin
      we = wr_q.pop_front();
      check("wr_addr_a", wr_addr_a_o, we.a);
      check("wr_addr_b", wr_addr_b_o, we.b);
    end

    exp_busy = (xf_q.size() > 0) && (cyc > xf_q[0].t0) && (cyc < xf_q[0].done);
    exp_done = (xf_q.size() > 0) && (cyc == xf_q[0].done);
    check("busy", busy_o, exp_busy);
    check("done", done_o, exp_done);
    if (exp_busy && !exp_rd) check("rd_addr_held", {rd_addr_a_o, rd_addr_b_o}, {4'(last_a), 4'(last_b)});
    if (exp_done) void'(xf_q.pop_front());
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Plans one transform: dir_j/dir_n force a hold of dir_n cycles before issue dir_j;
  // abort_at >= 0 pulls reset that many cycles after START.
  task automatic run_xfer(input int dir_j, input int dir_n, input bit rand_holds,
                          input bit spam, input int abort_at);
    int kind[256];
    int hl[NB];
    int t, t0, len, k, s, a;
    for (int i = 0; i < 256; i++) kind[i] = 0;
    for (int j = 0; j < NB; j++) begin
      hl[j] = 0;
      if (rand_holds && $urandom_range(0, 5) == 0) hl[j] = $urandom_range(1, 2);
      if (j == dir_j) hl[j] = dir_n;
    end
    t0 = cyc;
    t  = 1;
    for (int j = 0; j < NB; j++) begin
      if (j > 0 && j % HALF == 0) t += BF_LAT;
      for (int h = 0; h < hl[j]; h++) begin
        kind[t] = 1;
        t++;
      end
      kind[t] = 2;
      k = j % HALF;
      s = j / HALF;
      a = leg_a(k, s);
      rd_q.push_back('{t0 + t, a, a + (1 << s), s, (k == HALF - 1)});
      wr_q.push_back('{t0 + t + BF_LAT, a, a + (1 << s)});
      t++;
    end
    len = (t - 1) + BF_LAT + 1;
    xf_q.push_back('{t0, t0 + len});

    for (int c = 0; c <= len; c++) begin
      start = (c == 0) || spam;
      if (kind[c] == 1)      hold = 1'b1;
      else if (kind[c] == 2) hold = 1'b0;
      else                   hold = rand_holds ? 1'($urandom_range(0, 1)) : 1'b0;
      if (c == abort_at) begin
        #1;
        rst_n = 1'b0;
        rd_q.delete();
        wr_q.delete();
        xf_q.delete();
        last_a = 0;
        last_b = 0;
        #1;
        check("async_reset_outputs",
              {rd_en_o, rd_addr_a_o, rd_addr_b_o, w_en_o, lay_en_o, wr_en_o,
               wr_addr_a_o, wr_addr_b_o, layer_o, busy_o, done_o}, 0);
        start = 1'b0;
        hold  = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        next_cycle();
        return;
      end
      next_cycle();
    end
    start = 1'b0;
    hold  = 1'b0;
  endtask

  initial begin
    #1;
    check("reset_outputs",
          {rd_en_o, rd_addr_a_o, rd_addr_b_o, w_en_o, lay_en_o, wr_en_o,
           wr_addr_a_o, wr_addr_b_o, layer_o, busy_o, done_o}, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    next_cycle();
    next_cycle();

    run_xfer(-1, 0, 1'b0, 1'b0, -1);           // plain zero-hold transform
    next_cycle();
    run_xfer(HALF + 3, 2, 1'b0, 1'b0, -1);     // hold 2 cycles at k=3 of layer 1
    run_xfer(HALF - 1, 1, 1'b0, 1'b0, -1);     // hold on last issue of layer 0
    next_cycle();
    run_xfer(-1, 0, 1'b0, 1'b0, 2 * (HALF + BF_LAT) + HALF + 2); // reset in layer 2 drain
    next_cycle();
    run_xfer(-1, 0, 1'b0, 1'b0, -1);           // clean transform after reset
    run_xfer(-1, 0, 1'b0, 1'b1, -1);           // START held through BUSY and DONE
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(0, 2)) next_cycle();
      run_xfer(-1, 0, 1'b1, 1'($urandom_range(0, 1)), -1);
    end

    repeat (BF_LAT + 4) next_cycle();
    check("rd_queue_drained", rd_q.size(), 0);
    check("wr_queue_drained", wr_q.size(), 0);
    check("xfer_queue_drained", xf_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_iter_ctrl.md
Name: fft_iter_ctrl

Overview:
- Sequencing controller for the iterative radix-2 DIT FFT core.
- Sits directly upstream of the twiddle address generator. It drives that block's per-butterfly EN and per-layer LAY_EN strobes.
- Also generates read and write data-memory address pairs for the fixed-latency butterfly pipeline, and a START/BUSY/DONE handshake toward the host sequencer.
- One transform covers N = 2^AWL points, AWL layers, and N/2 butterflies per layer.

Parameters:
- AWL, 5: data address width; N = 2^AWL points; must be ≥ 2.
- BF_LAT, 3: butterfly pipeline latency in cycles, from read issue to write-back; must be ≥ 1.
- LWL, 3: width of the LAYER output; must satisfy 2^LWL ≥ AWL.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; asynchronous, active-low.
- START  in  1  single-cycle request to begin a transform; sampled only in IDLE.
- HOLD  in  1  while high in RUN, no new butterfly is issued; drain and write-back continue.
- RD_EN  out  1  butterfly read issue strobe.
- RD_ADDR_A  out  AWL  upper-leg read address.
- RD_ADDR_B  out  AWL  lower-leg read address.
- W_EN  out  1  twiddle generator advance; connects to the twiddle generator's EN.
- LAY_EN  out  1  twiddle generator layer rotate; connects to its LAY_EN.
- WR_EN  out  1  write-back strobe, equal to RD_EN delayed by BF_LAT cycles.
- WR_ADDR_A  out  AWL  RD_ADDR_A delayed by BF_LAT cycles.
- WR_ADDR_B  out  AWL  RD_ADDR_B delayed by BF_LAT cycles.
- LAYER  out  LWL  current layer index s.
- BUSY  out  1  high in RUN and DRAIN.
- DONE  out  1  one-cycle completion pulse.

Behaviour:
- Reset (RST low, asynchronous):
  - FSM goes to IDLE.
  - All outputs are 0.
  - Butterfly counter k and layer s are 0.
  - The write delay line is cleared (all WR_EN stages 0).
- FSM states: IDLE, RUN, DRAIN, FIN.
- IDLE:
  - START=1 moves to RUN next cycle, with k=0 and s=0.
  - START in any other state is ignored.
- RUN, issue cycle (HOLD=0):
  - RD_EN=1 and W_EN=1.
  - RD_ADDR_A is k (AWL-1 bits) with a 0 inserted at bit position s; RD_ADDR_B = RD_ADDR_A | (1<<s).
  - Then k increments.
- RUN with HOLD=1:
  - RD_EN=0, W_EN=0, LAY_EN=0; k frozen.
  - Address outputs keep their last value.
- Last issue of a layer (k = N/2-1 with HOLD=0):
  - LAY_EN=1 in the same cycle as W_EN. The generator accumulates with the old stride, so its masked address returns to 0 for the next layer.
  - k wraps to 0; FSM goes to DRAIN.
- DRAIN:
  - Lasts exactly BF_LAT cycles; no issue, HOLD ignored.
  - If s < AWL-1: s increments and FSM returns to RUN, so the first read of the next layer is one cycle after the last write of the previous layer (no RAW hazard).
  - If s = AWL-1: FSM goes to FIN.
- FIN:
  - DONE=1 for one cycle, BUSY=0, then IDLE; s resets to 0.
- Write delay line:
  - A BF_LAT-deep shift register carries {RD_EN, RD_ADDR_A, RD_ADDR_B} and shifts every cycle regardless of HOLD.
  - WR_EN is 1 exactly BF_LAT cycles after each RD_EN.
  - When WR_EN=0, WR_ADDR_* values are don't-care but deterministic (shifted values).
- Timing:
  - Zero-HOLD transform: START sampled at cycle 0, first RD_EN at cycle 1.
  - Each layer takes N/2 + BF_LAT cycles.
  - DONE at cycle AWL*(N/2+BF_LAT)+1.
  - Exactly N/2*AWL RD_EN pulses, N/2*AWL WR_EN pulses, and AWL LAY_EN pulses.
- Reset mid-operation:
  - Immediate return to IDLE; in-flight writes are discarded (WR_EN forced 0).
  - Twiddle generator is reset by the same RST, so both blocks restart aligned.
- HOLD asserted exactly on the last issue cycle: issue deferred; LAY_EN fires only with the deferred issue.

Test Plan:
- AWL=4, BF_LAT=3, START at cycle 0, HOLD=0 → RD_EN high cycles 1–8, 12–19, 23–30, 34–41; LAY_EN at cycles 8, 19, 30, 41; DONE at cycle 45; BUSY high cycles 1–44.
- Same config, address check → layer 0 pairs (0,1),(2,3)…(14,15); layer 1 starts (0,2),(1,3),(4,6); layer 3 pairs (0,8)…(7,15); the attached twiddle generator's W_ADDR in layer 2 is 0,2,4,6,0,2,4,6.
- WR_* equals RD_* delayed 3 cycles → every (WR_ADDR_A, WR_ADDR_B) with WR_EN=1 matches the RD pair from 3 cycles earlier; the last write of each layer precedes the next layer's first read by 1 cycle.
- HOLD high for 2 cycles at k=3 of layer 1 → RD_EN and W_EN low for those cycles, address stable, k resumes at 3; DONE delayed by 2 cycles (cycle 47).
- RST pulled low during layer 2 DRAIN → all outputs 0 asynchronously; after release, START gives a full transform identical to the first scenario with correct twiddle alignment.
- START held high during BUSY, and START coincident with DONE → ignored; exactly one transform is run.
